md_ctrl: RTL and testbench

//  Iterative multiply/divide controller for the EX stage. It runs MULT/MULTU/DIV/DIVU over

---
 rtl/md_ctrl_pkg.sv | 28 ++
 rtl/md_addsub.sv | 19 +
 rtl/md_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_md_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared opcode/state constants and opcode-decode helpers for the multiply/divide controller.
package md_ctrl_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV_S = 2'd2;
    localparam logic [1:0] MD_FIX  = 2'd3;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_addsub.sv
// Combinational add/subtract with carry out; shared by the multiply and divide iterations.
module md_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum_c,
    output logic         carry_c
);

    logic [W:0] full;

    // Subtraction as x + ~y + 1; carry out set means no borrow (x >= y).
    assign full    = {1'b0, x} + {1'b0, (sub ? ~y : y)} + (W+1)'(sub);
    assign sum_c   = full[W-1:0];
    assign carry_c = full[W];

endmodule

// File: rtl/md_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO; MTHI/MTLO complete in one cycle.
// Optional abort port and behaviour enabled by defining MD_ABORT_EN.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MD_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] opnd;
    logic             neg_p;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             is_div;
    logic             abort_hit;
    logic             last_step;

    logic [AW-1:0]    add_x;
    logic [AW-1:0]    add_y;
    logic             add_sub;
    logic [AW-1:0]    add_sum;
    logic             add_carry;

    logic             op_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef MD_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Most negative input maps to unsigned 2^(WIDTH-1) naturally.
    assign op_signed = op_is_signed(op);
    assign a_abs     = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_abs     = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    assign prod      = {acc, qreg};
    assign prod_fix  = neg_p ? (~prod + PW'(1)) : prod;
    assign quot_fix  = neg_q ? (~qreg + WIDTH'(1)) : qreg;
    assign rem_fix   = neg_r ? (~acc + WIDTH'(1)) : acc;

    // Adder operand steering: trial subtract in DIV, conditional add otherwise.
    always_comb begin
        add_x   = {1'b0, acc};
        add_y   = qreg[0] ? {1'b0, opnd} : '0;
        add_sub = 1'b0;
        if (state == MD_DIV_S) begin
            add_x   = {acc, qreg[WIDTH-1]};
            add_y   = {1'b0, opnd};
            add_sub = 1'b1;
        end
    end

    md_addsub #(.W(AW)) u_addsub (
        .x       (add_x),
        .y       (add_y),
        .sub     (add_sub),
        .sum_c   (add_sum),
        .carry_c (add_carry)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    if (op_is_mul(op)) begin
                        state_next = MD_MUL;
                    end else if (op_is_div(op)) begin
                        state_next = (b == '0) ? MD_FIX : MD_DIV_S;
                    end
                end
            end
            MD_MUL, MD_DIV_S: begin
                if (last_step) begin
                    state_next = MD_FIX;
                end
            end
            default: state_next = MD_IDLE;
        endcase
        if (abort_hit && (state != MD_IDLE)) begin
            state_next = MD_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != MD_IDLE);
            done <= (state == MD_FIX) && !abort_hit;
        end
    end

    // Working registers and HI/LO; results land only on the FIX exit edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            qreg   <= '0;
            opnd   <= '0;
            neg_p  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (op == MD_MTHI) begin
                            hi <= a;
                        end else if (op == MD_MTLO) begin
                            lo <= a;
                        end else if (op_is_mul(op)) begin
                            acc    <= '0;
                            qreg   <= b_abs;
                            opnd   <= a_abs;
                            neg_p  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            is_div <= 1'b0;
                            dz     <= 1'b0;
                        end else if (op_is_div(op)) begin
                            acc    <= '0;
                            qreg   <= a_abs;
                            opnd   <= b_abs;
                            neg_p  <= 1'b0;
                            neg_q  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r  <= op_signed && a[WIDTH-1];
                            is_div <= 1'b1;
                            dz     <= (b == '0);
                        end
                    end
                end
                MD_MUL: begin
                    acc  <= add_sum[WIDTH:1];
                    qreg <= {add_sum[0], qreg[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                MD_DIV_S: begin
                    acc  <= add_carry ? add_sum[WIDTH-1:0] : {acc[WIDTH-2:0], qreg[WIDTH-1]};
                    qreg <= {qreg[WIDTH-2:0], add_carry};
                    cnt  <= cnt + CNT_W'(1);
                end
                default: begin
                    if (!abort_hit && !dz) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized and directed checks of md_ctrl against an arithmetic reference model.
`timescale 1ns/1ps
module tb_md_ctrl;
    import md_ctrl_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MD_ABORT_EN
    logic         abort;
`endif

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    md_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MD_ABORT_EN
        .abort (abort),
`endif
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; lat is the done cycle (0 = immediate/no-op).
    task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic [W-1:0] nh, output logic [W-1:0] nl);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        nh  = m_hi;
        nl  = m_lo;
        lat = W + 2;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = x;
        uy  = y;
        case (o)
            MD_MULT:  {nh, nl} = 64'(sx * sy);
            MD_MULTU: {nh, nl} = 64'(ux * uy);
            MD_DIV: begin
                if (y == 0) lat = 2;
                else begin
                    nl = 32'(sx / sy);
                    nh = 32'(sx % sy);
                end
            end
            MD_DIVU: begin
                if (y == 0) lat = 2;
                else begin
                    nl = 32'(ux / uy);
                    nh = 32'(ux % uy);
                end
            end
            MD_MTHI: begin lat = 0; nh = x; end
            MD_MTLO: begin lat = 0; nl = x; end
            default: lat = 0;
        endcase
    endtask

    // Issue one request from IDLE; optionally re-assert start at cycle inj while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inj);
        int           lat;
        int           cyc;
        int           nbusy;
        logic         held;
        logic [W-1:0] nh;
        logic [W-1:0] nl;
        model(o, x, y, lat, nh, nl);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        step();
        start = 1'b0;
        op = 3'($urandom);
        a = $urandom;
        b = $urandom;
        if (lat == 0) begin
            check({tag, " busy"}, 64'(busy), 64'd0);
            check({tag, " done"}, 64'(done), 64'd0);
            check({tag, " hi"}, 64'(hi), 64'(nh));
            check({tag, " lo"}, 64'(lo), 64'(nl));
        end else begin
            cyc = 1;
            nbusy = 0;
            held = 1'b1;
            while (!done && cyc < lat + 20) begin
                if (busy) nbusy++;
                if (hi !== m_hi || lo !== m_lo) held = 1'b0;
                start = (cyc == inj);
                if (cyc == inj) begin
                    op = MD_DIVU;
                    a = 32'd9;
                    b = 32'd3;
                end
                step();
                cyc++;
            end
            start = 1'b0;
            check({tag, " latency"}, 64'(cyc), 64'(lat));
            check({tag, " busy cycles"}, 64'(nbusy), 64'(lat - 1));
            check({tag, " hold"}, 64'(held), 64'd1);
            check({tag, " busy at done"}, 64'(busy), 64'd0);
            check({tag, " hi"}, 64'(hi), 64'(nh));
            check({tag, " lo"}, 64'(lo), 64'(nl));
        end
        m_hi = nh;
        m_lo = nl;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   ro;
        int           seen;
        reset = 1'b0;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
`ifdef MD_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) step();
        reset = 1'b1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);

        run_op("multu max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu max hi const", 64'(hi), 64'hFFFF_FFFE);
        check("multu max lo const", 64'(lo), 64'h0000_0001);
        step();
        check("done pulse width", 64'(done), 64'd0);

        run_op("mult -3*5", MD_MULT, -32'sd3, 32'sd5, -1);
        check("mult hi const", 64'(hi), 64'hFFFF_FFFF);
        check("mult lo const", 64'(lo), 64'hFFFF_FFF1);
        run_op("div -7/2", MD_DIV, -32'sd7, 32'sd2, -1);
        check("div lo const", 64'(lo), 64'hFFFF_FFFD);
        check("div hi const", 64'(hi), 64'hFFFF_FFFF);
        run_op("div minneg/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div minneg lo const", 64'(lo), 64'h8000_0000);
        check("div minneg hi const", 64'(hi), 64'h0);

        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'h0, -1);
        check("mthi hi const", 64'(hi), 64'h1234_5678);
        run_op("divu by 0", MD_DIVU, 32'd5, 32'd0, -1);
        check("dz hi const", 64'(hi), 64'h1234_5678);
        run_op("mtlo", MD_MTLO, 32'hCAFE_F00D, 32'h0, -1);
        run_op("op6", 3'd6, 32'h1, 32'h2, -1);
        run_op("op7", 3'd7, 32'h3, 32'h4, -1);

        run_op("multu 6*7 ignore start", MD_MULTU, 32'd6, 32'd7, 10);
        check("6*7 lo const", 64'(lo), 64'd42);
        run_op("divu in done cycle", MD_DIVU, 32'd9, 32'd3, -1);
        check("9/3 lo const", 64'(lo), 64'd3);

        // Synchronous reset in the middle of a divide.
        start = 1'b1;
        op = MD_DIV;
        a = 32'd1000;
        b = 32'd7;
        step();
        start = 1'b0;
        repeat (14) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        m_hi = '0;
        m_lo = '0;
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            step();
        end
        check("midreset no done", 64'(seen), 64'd0);

`ifdef MD_ABORT_EN
        run_op("mthi pre-abort", MD_MTHI, 32'h0BAD_0BAD, 32'h0, -1);
        start = 1'b1;
        op = MD_MULT;
        a = 32'd1234;
        b = -32'sd99;
        step();
        start = 1'b0;
        repeat (19) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'(m_hi));
        check("abort lo", 64'(lo), 64'(m_lo));
        seen = 0;
        repeat (40) begin
            if (done || busy) seen++;
            step();
        end
        check("abort no done", 64'(seen), 64'd0);
        abort = 1'b1;
        repeat (3) step();
        abort = 1'b0;
        check("idle abort busy", 64'(busy), 64'd0);
        check("idle abort hi", 64'(hi), 64'(m_hi));
        run_op("after idle abort", MD_MULTU, 32'd11, 32'd13, -1);
`endif

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
